memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares the single-port unified instruction/data memory of the multicycle core between two requesters: the core's memory port (fetch, `lw`, `sw`) and the program-loader port used to preload or inspect memory. Every access runs a fixed three-state sequence. Ties between the two requesters are broken round-robin. Out-of-range accesses complete harmlessly. The block sits between the core datapath's address/write-data muxes and the memory array; the core stalls its state machine until its ready pulse arrives.

## Interface
- `ADDR_WIDTH`, 32, byte-address width of both requester ports
- `DATA_WIDTH`, 32, word width
- `MEM_DEPTH`, 1024, memory size in words; `mem_addr` width is `$clog2(MEM_DEPTH)`

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `core_req`  in  1  core access request; held with addr/we/wdata until `core_ready`
- `core_we`  in  1  1 = write, 0 = read
- `core_addr`  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- `core_wdata`  in  DATA_WIDTH  write data
- `core_ready`  out  1  one-cycle completion pulse
- `core_rdata`  out  DATA_WIDTH  read data, valid while `core_ready`=1
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ready`, `ldr_rdata`  loader port, identical semantics
- `mem_addr`  out  clog2(MEM_DEPTH)  word address to the array
- `mem_we`  out  1  array write enable
- `mem_wdata`  out  DATA_WIDTH  array write data
- `mem_rdata`  in  DATA_WIDTH  synchronous-read data, valid the cycle after `mem_addr` is presented

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE
  - all ready = 0, all rdata = 0
  - mem_addr = 0, mem_we = 0, mem_wdata = 0
  - `last_grant` = LOADER, so the core wins the first tie
- **IDLE:**
  - A requester is eligible when its req = 1 and its ready = 0; a requester still showing ready is ignored that cycle.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not `last_grant`.
  - On grant, register `mem_addr = addr[.. :2]` and `mem_wdata = wdata`, and set `last_grant`.
  - Range check: `mem_we = we & in_range`, where `in_range = (addr>>2) < MEM_DEPTH`. Store `in_range` and the grant internally.
  - Go to ACCESS.
- **ACCESS:**
  - The array sees the address/write for one cycle.
  - At the edge: mem_we <= 0; go to RESP.
  - `mem_we` is never high for more than one cycle.
- **RESP:**
  - `mem_rdata` is valid.
  - At the edge: the granted rdata <= (in_range ? mem_rdata : 0), the granted ready <= 1, go to IDLE.
  - For writes, rdata is loaded with the same value and has no meaning.
- Ready clears automatically after one cycle. The rdata register holds until the next completion to that port.
- Requests are not preempted. A request arriving during ACCESS/RESP waits in IDLE arbitration.
- Out of range:
  - writes are suppressed
  - reads return 0
  - ready still pulses with normal latency
- The non-granted port's outputs are unchanged during an access.

## Timing
- Request latency:
  - Req sampled high at the end of cycle N (state IDLE).
  - ACCESS in N+1, RESP in N+2, ready = 1 in N+3.
  - The requester drops req, or changes the request, at the end of N+3.
- A requester holding req continuously is re-eligible in N+4 (the ready-mask excludes N+3).
- The other requester, if waiting, is granted at the end of N+3.
- Peak throughput: one access per 3 cycles when alternating, per 4 cycles for a single requester.
- Asynchronous reset mid-access (any state):
  - all outputs go to reset values immediately
  - a partially issued write whose `mem_we` was already sampled by the array is not undone
  - the requester must re-issue

## Test plan
- **Reset:** hold `reset_n`=0 with both req=1 → all outputs 0. Release → core granted first; `mem_addr` updates the cycle after release.
- **Core read:** memory word 5 = 0xDEADBEEF; core_req=1, we=0, addr=0x14 at cycle N → mem_addr=5 in N+1, core_ready=1 and core_rdata=0xDEADBEEF in N+3 only. `mem_we` stays 0 throughout.
- **Loader write then core read:** ldr writes 0x12345678 to addr 0x40 → mem_we=1 for exactly one cycle with mem_addr=16, ldr_ready at N+3. A core read of 0x40 afterwards returns 0x12345678.
- **Tie round-robin:** both req held continuously → grant order core, ldr, core, ldr. Ready pulses alternate, 3 cycles apart.
- **Out of range:** MEM_DEPTH=1024; core write to addr 0x1000 → mem_we never 1, core_ready at N+3. A read of 0x1000 → core_rdata=0.
- **Reset mid-access:** assert `reset_n`=0 during ACCESS of a loader read → ldr_ready never pulses, state IDLE. After release, a re-issued request completes with 3-cycle latency.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sharing of the unified single-port
// memory between the core and the program loader.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ready,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_ready,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int WW = ADDR_WIDTH - 2;
  localparam logic CORE = 1'b0;
  localparam logic LDR  = 1'b1;
  localparam logic [WW-1:0] DEPTH = WW'(MEM_DEPTH);

  state_t state, state_d;

  logic last_grant;
  logic grant;
  logic in_range_q;

  logic core_elig;
  logic ldr_elig;
  logic take;
  logic sel;
  logic [WW-1:0] sel_word;
  logic sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic sel_in_range;

  // Byte offset within a word plays no part in a word access
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^{core_addr[1:0], ldr_addr[1:0]};

  always_comb begin
    state_d   = state;
    take      = 1'b0;
    sel       = CORE;
    core_elig = core_req & ~core_ready;
    ldr_elig  = ldr_req & ~ldr_ready;
    unique case (state)
      IDLE: begin
        take = core_elig | ldr_elig;
        if (core_elig & ldr_elig) sel = ~last_grant;
        else sel = ldr_elig;
        if (take) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_word     = '0;
    sel_we       = 1'b0;
    sel_wdata    = '0;
    unique case (1'b1)
      (sel == LDR): begin
        sel_word  = ldr_addr[ADDR_WIDTH-1:2];
        sel_we    = ldr_we;
        sel_wdata = ldr_wdata;
      end
      default: begin
        sel_word  = core_addr[ADDR_WIDTH-1:2];
        sel_we    = core_we;
        sel_wdata = core_wdata;
      end
    endcase
    sel_in_range = sel_word < DEPTH;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= LDR;
      grant      <= CORE;
      in_range_q <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      core_ready <= 1'b0;
      core_rdata <= '0;
      ldr_ready  <= 1'b0;
      ldr_rdata  <= '0;
    end else begin
      state      <= state_d;
      mem_we     <= 1'b0;
      core_ready <= 1'b0;
      ldr_ready  <= 1'b0;
      if (take) begin
        grant      <= sel;
        last_grant <= sel;
        in_range_q <= sel_in_range;
        mem_addr   <= sel_word[AW-1:0];
        mem_wdata  <= sel_wdata;
        mem_we     <= sel_we & sel_in_range;
      end
      // Out-of-range reads complete with zero data
      if (state == RESP) begin
        if (grant == LDR) begin
          ldr_ready <= 1'b1;
          ldr_rdata <= in_range_q ? mem_rdata : '0;
        end else begin
          core_ready <= 1'b1;
          core_rdata <= in_range_q ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: randomized self-checking bench for
// memory_arbiter against a word-array reference model.
module tb_memory_arbiter;

  logic clock = 1'b0;
  logic reset_n;
  logic core_req, core_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic core_ready;
  logic ldr_req, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic ldr_ready;
  logic [9:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] array [1024];
  logic [31:0] ref_mem [1024];
  logic pre_we = 1'b0;
  logic [9:0] pre_a = '0;
  logic [31:0] pre_d = '0;
  int we_total = 0;
  int we_run = 0;
  int we_max = 0;
  logic model_last;

  memory_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH(1024)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .core_req(core_req),
    .core_we(core_we),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_ready(core_ready),
    .core_rdata(core_rdata),
    .ldr_req(ldr_req),
    .ldr_we(ldr_we),
    .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_ready(ldr_ready),
    .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_we) array[pre_a] <= pre_d;
    else if (mem_we) array[mem_addr] <= mem_wdata;
    mem_rdata <= array[mem_addr];
  end

  always @(posedge clock) begin
    if (mem_we === 1'b1) begin
      we_total++;
      we_run++;
    end else begin
      we_run = 0;
    end
    if (we_run > we_max) we_max = we_run;
  end

  task automatic access(input logic p, input logic we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output int lat,
                        output logic [31:0] rd,
                        output logic [9:0] a1,
                        output logic rdy_after);
    if (p) begin
      ldr_req = 1'b1; ldr_we = we;
      ldr_addr = a; ldr_wdata = d;
    end else begin
      core_req = 1'b1; core_we = we;
      core_addr = a; core_wdata = d;
    end
    lat = -1;
    rd = '0;
    a1 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (c == 1) a1 = mem_addr;
      if ((p && ldr_ready) || (!p && core_ready)) begin
        lat = c;
        rd = p ? ldr_rdata : core_rdata;
        break;
      end
    end
    if (lat > 0) model_last = p;
    if (p) ldr_req = 1'b0;
    else core_req = 1'b0;
    @(posedge clock); #1;
    rdy_after = p ? ldr_ready : core_ready;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0;
    core_addr = 32'h14; core_wdata = '0;
    ldr_req = 1'b1; ldr_we = 1'b0;
    ldr_addr = 32'h40; ldr_wdata = '0;
    model_last = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pre_a = 10'(i);
      pre_d = (i == 5) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pre_d;
      pre_we = 1'b1;
      @(posedge clock); #1;
    end
    pre_we = 1'b0;
    checks++;
    if (core_ready !== 1'b0 || ldr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b want 0/0",
               core_ready, ldr_ready);
    end
    checks++;
    if (core_rdata !== 32'h0 || ldr_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0",
               core_rdata, ldr_rdata);
    end
    checks++;
    if (mem_addr !== 10'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: got %h/%b/%h want 0/0/0",
               mem_addr, mem_we, mem_wdata);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (mem_addr !== 10'd5) begin
      errors++;
      $display("FAIL reset_first_grant: mem_addr got %0d want 5", mem_addr);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++;
    if (core_ready !== 1'b1 || ldr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_core_first: got %b/%b want 1/0",
               core_ready, ldr_ready);
    end
    checks++;
    if (core_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_core_rdata: got %h want deadbeef", core_rdata);
    end
    model_last = 1'b0;
    core_req = 1'b0;
    ldr_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_core_read();
    int lat, w0;
    logic [31:0] rd;
    logic [9:0] a1;
    logic ra;
    w0 = we_total;
    access(1'b0, 1'b0, 32'h14, 32'h0, lat, rd, a1, ra);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL core_read_lat: got %0d want 3", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL core_read_data: got %h want deadbeef", rd);
    end
    checks++;
    if (a1 !== 10'd5) begin
      errors++;
      $display("FAIL core_read_addr: got %0d want 5", a1);
    end
    checks++;
    if (ra !== 1'b0) begin
      errors++;
      $display("FAIL core_read_pulse: ready after got %b want 0", ra);
    end
    checks++;
    if (we_total != w0) begin
      errors++;
      $display("FAIL core_read_we: got %0d writes want 0", we_total - w0);
    end
  endtask

  task automatic test_ldr_write_core_read();
    int lat, w0;
    logic [31:0] rd;
    logic [9:0] a1;
    logic ra;
    w0 = we_total;
    access(1'b1, 1'b1, 32'h40, 32'h12345678, lat, rd, a1, ra);
    ref_mem[16] = 32'h12345678;
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL ldr_write_lat: got %0d want 3", lat);
    end
    checks++;
    if (a1 !== 10'd16) begin
      errors++;
      $display("FAIL ldr_write_addr: got %0d want 16", a1);
    end
    checks++;
    if (we_total - w0 != 1 || we_max != 1) begin
      errors++;
      $display("FAIL ldr_write_we: got %0d pulses run %0d want 1 run 1",
               we_total - w0, we_max);
    end
    access(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, a1, ra);
    checks++;
    if (rd !== ref_mem[16] || lat != 3) begin
      errors++;
      $display("FAIL core_readback: got %h lat %0d want %h lat 3",
               rd, lat, ref_mem[16]);
    end
  endtask

  task automatic test_round_robin();
    logic exp;
    int pulses;
    logic [31:0] ca, la, wa, exp_rd, got_rd;
    ca = 32'($urandom_range(0, 1023)) << 2;
    la = 32'($urandom_range(0, 1023)) << 2;
    core_req = 1'b1; core_we = 1'b0; core_addr = ca;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = la;
    exp = ~model_last;
    pulses = 0;
    for (int c = 1; c <= 16 && pulses < 4; c++) begin
      @(posedge clock); #1;
      if (core_ready === 1'b1 && ldr_ready === 1'b1) begin
        errors++;
        $display("FAIL rr_both_ready: cycle %0d", c);
      end
      if (core_ready === 1'b1 || ldr_ready === 1'b1) begin
        pulses++;
        checks++;
        if (ldr_ready !== exp || c != 3 * pulses) begin
          errors++;
          $display("FAIL rr_order: got ldr=%b at %0d want ldr=%b at %0d",
                   ldr_ready, c, exp, 3 * pulses);
        end
        wa = exp ? la : ca;
        exp_rd = ref_mem[wa[11:2]];
        got_rd = exp ? ldr_rdata : core_rdata;
        checks++;
        if (got_rd !== exp_rd) begin
          errors++;
          $display("FAIL rr_data: got %h want %h", got_rd, exp_rd);
        end
        model_last = exp;
        exp = ~exp;
      end
    end
    core_req = 1'b0;
    ldr_req = 1'b0;
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d pulses want 4", pulses);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_out_of_range();
    int lat, w0;
    logic [31:0] rd;
    logic [9:0] a1;
    logic ra;
    w0 = we_total;
    access(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, lat, rd, a1, ra);
    checks++;
    if (lat != 3 || we_total != w0) begin
      errors++;
      $display("FAIL oor_write: got lat %0d writes %0d want lat 3 writes 0",
               lat, we_total - w0);
    end
    access(1'b0, 1'b0, 32'h1000, 32'h0, lat, rd, a1, ra);
    checks++;
    if (rd !== 32'h0 || lat != 3) begin
      errors++;
      $display("FAIL oor_read: got %h lat %0d want 0 lat 3", rd, lat);
    end
    access(1'b1, 1'b0, 32'h0, 32'h0, lat, rd, a1, ra);
    checks++;
    if (rd !== ref_mem[0]) begin
      errors++;
      $display("FAIL oor_alias: word0 got %h want %h", rd, ref_mem[0]);
    end
  endtask

  task automatic test_random();
    int lat, w0, exp_w;
    logic [31:0] rd, a, d, exp_rd;
    logic [9:0] a1;
    logic ra, p, we, inr;
    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      d = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h1000 | $urandom;
      else a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3));
      inr = (a >> 2) < 32'd1024;
      exp_w = (we && inr) ? 1 : 0;
      exp_rd = inr ? ref_mem[a[11:2]] : 32'h0;
      w0 = we_total;
      access(p, we, a, d, lat, rd, a1, ra);
      checks++;
      if (lat != 3 || we_total - w0 != exp_w) begin
        errors++;
        $display("FAIL rand_access %0d: lat %0d writes %0d want 3 %0d",
                 i, lat, we_total - w0, exp_w);
      end
      if (!we) begin
        checks++;
        if (rd !== exp_rd) begin
          errors++;
          $display("FAIL rand_read %0d: addr %h got %h want %h",
                   i, a, rd, exp_rd);
        end
      end
      if (we && inr) ref_mem[a[11:2]] = d;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    logic [9:0] a1;
    logic ra, seen;
    ldr_req = 1'b1; ldr_we = 1'b0;
    ldr_addr = 32'h80; ldr_wdata = '0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    ldr_req = 1'b0;
    checks++;
    if (mem_addr !== 10'h0 || mem_we !== 1'b0 || ldr_ready !== 1'b0 ||
        ldr_rdata !== 32'h0 || core_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h/%b/%b/%h/%h want all 0",
               mem_addr, mem_we, ldr_ready, ldr_rdata, core_rdata);
    end
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      if (ldr_ready === 1'b1) seen = 1'b1;
    end
    reset_n = 1'b1;
    model_last = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      if (ldr_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pulse: ldr_ready got 1 want 0");
    end
    access(1'b1, 1'b0, 32'h80, 32'h0, lat, rd, a1, ra);
    checks++;
    if (lat != 3 || rd !== ref_mem[32]) begin
      errors++;
      $display("FAIL mid_reset_reissue: got lat %0d %h want 3 %h",
               lat, rd, ref_mem[32]);
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_ldr_write_core_read();
    test_round_robin();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
